// File: rtl/seg7_scan_decoder.sv
// Recovers digit values from a multiplexed 7-segment bus: waits for HEX/AN to settle, decodes the
// glyph for the driven digit, and publishes all eight digits together once each has been captured.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  HEX,
  input  logic [7:0]  AN,
  output logic [31:0] digits,
  output logic [7:0]  dp,
  output logic [7:0]  blank,
  output logic        frame_done,
  output logic        frame_valid,
  output logic        err_glyph,
  output logic        err_multi
);
  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] sample_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] sh_digits_q;
  logic [7:0]  sh_dp_q, sh_blank_q;

  logic       changed, capture, single, legal, cap_ok, frame_full;
  logic [2:0] idx;
  logic [3:0] nib;

  // Returns {legal, nibble}; all segments off is a legal blank digit reading as 0.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h00:   decode = 5'h10;
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h79:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    changed = ({AN, HEX} != sample_q);
    if (changed)                 cnt_d = '0;
    else if (cnt_q >= SETTLE_MAX) cnt_d = SETTLE_MAX;
    else                         cnt_d = cnt_q + 8'd1;

    // Capture fires only on the SETTLE->HOLD transition, so a long hold is captured once.
    state_d = state_q;
    capture = 1'b0;
    if (AN == 8'hFF) begin
      state_d = IDLE;
    end else if (changed) begin
      state_d = SETTLE;
    end else if (state_q == SETTLE && cnt_d == SETTLE_MAX) begin
      state_d = HOLD;
      capture = 1'b1;
    end

    single = $onehot(~AN);
    idx    = '0;
    for (int i = 0; i < 8; i++) begin
      if (!AN[i]) idx = 3'(i);
    end
    {legal, nib} = decode(~HEX[6:0]);
    cap_ok       = capture && single && legal;
    frame_full   = (seen_q == 8'hFF);

    // Frame completion clears the mask first; a coincident capture lands in the fresh mask.
    seen_d = frame_full ? 8'h00 : seen_q;
    if (cap_ok) seen_d[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sample_q    <= 16'hFF00;
      cnt_q       <= '0;
      seen_q      <= '0;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      digits      <= '0;
      dp          <= '0;
      blank       <= '0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      err_glyph   <= 1'b0;
      err_multi   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_q   <= {AN, HEX};
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      err_glyph  <= capture && single && !legal;
      err_multi  <= capture && !single;
      frame_done <= frame_full;
      if (frame_full) begin
        digits      <= sh_digits_q;
        dp          <= sh_dp_q;
        blank       <= sh_blank_q;
        frame_valid <= 1'b1;
      end
      if (cap_ok) begin
        sh_digits_q[{idx, 2'b00} +: 4] <= nib;
        sh_dp_q[idx]                   <= ~HEX[7];
        sh_blank_q[idx]                <= (HEX[6:0] == 7'h7F);
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues expected frames/errors, monitor pops them.
module tb_seg7_scan_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  HEX, AN;
  logic [31:0] digits;
  logic [7:0]  dp, blank;
  logic        frame_done, frame_valid, err_glyph, err_multi;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .HEX(HEX), .AN(AN),
    .digits(digits), .dp(dp), .blank(blank),
    .frame_done(frame_done), .frame_valid(frame_valid),
    .err_glyph(err_glyph), .err_multi(err_multi)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  b;
    int          due;
  } frame_t;

  typedef struct {
    logic [1:0] kind;  // {multi, glyph}
    int         due;
  } err_t;

  frame_t fq[$];
  err_t   eq[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     digit_no = 0;
  logic   exp_fv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gl(input logic [3:0] n, input logic d);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return {~d, ~s};
  endfunction

  function automatic logic [7:0] an_of(input int i);
    logic [7:0] a;
    a = 8'hFF;
    a[i] = 1'b0;
    return a;
  endfunction

  task automatic drive(input logic [7:0] an, input logic [7:0] hex, input int n);
    AN  = an;
    HEX = hex;
    if (an != 8'hFF) digit_no++;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b, input int n);
    frame_t f;
    f.d = d; f.p = p; f.b = b; f.due = digit_no + n;
    fq.push_back(f);
  endtask

  task automatic push_err(input logic [1:0] k);
    err_t e;
    e.kind = k; e.due = digit_no + 1;
    eq.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge, inputs change on falling edges.
  initial begin
    frame_t      f;
    err_t        e;
    logic [47:0] prev;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_fv = 1'b0;
      end else begin
        if (frame_done) begin
          check("frame_done expected", 64'(fq.size() != 0), 64'd1);
          if (fq.size() != 0) begin
            f = fq.pop_front();
            check("frame digits", 64'(digits), 64'(f.d));
            check("frame dp", 64'(dp), 64'(f.p));
            check("frame blank", 64'(blank), 64'(f.b));
            check("frame timing digit index", 64'(digit_no), 64'(f.due));
            exp_fv = 1'b1;
          end
        end else begin
          check("outputs stable", 64'({digits, dp, blank}), 64'(prev));
        end
        check("frame_valid", 64'(frame_valid), 64'(exp_fv));
        if (err_glyph || err_multi) begin
          check("err expected", 64'(eq.size() != 0), 64'd1);
          if (eq.size() != 0) begin
            e = eq.pop_front();
            check("err kind", 64'({err_multi, err_glyph}), 64'(e.kind));
            check("err timing digit index", 64'(digit_no), 64'(e.due));
          end
        end
      end
      prev = {digits, dp, blank};
    end
  end

  initial begin
    rst = 1'b1;
    AN  = 8'hFF;
    HEX = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset digits", 64'(digits), 64'd0);
    check("reset dp", 64'(dp), 64'd0);
    check("reset blank", 64'(blank), 64'd0);
    check("reset pulses", 64'({frame_done, frame_valid, err_glyph, err_multi}), 64'd0);
    rst = 1'b0;
    drive(8'hFF, 8'hFF, 2);

    // Basic scan: glyphs 0..7, decimal point on digit 3.
    push_frame(32'h76543210, 8'h08, 8'h00, 8);
    for (int i = 0; i < 8; i++) drive(an_of(i), gl(4'(i), i == 3), 6);
    drive(8'hFF, 8'hFF, 4);
    check("frame_valid after first frame", 64'(frame_valid), 64'd1);

    // Too short to settle: nothing captured.
    for (int i = 0; i < 8; i++) drive(an_of(i), gl(4'h9, 1'b0), 3);
    drive(8'hFF, 8'hFF, 8);

    // Blank digit 2, glyph F elsewhere; digit 0 recaptured, last value wins.
    push_frame(32'hFFFFF0FF, 8'h00, 8'h04, 9);
    drive(an_of(0), gl(4'h5, 1'b0), 6);
    for (int i = 1; i < 7; i++) drive(an_of(i), (i == 2) ? 8'hFF : gl(4'hF, 1'b0), 6);
    drive(an_of(0), gl(4'hF, 1'b0), 6);
    drive(an_of(7), gl(4'hF, 1'b0), 6);
    drive(8'hFF, 8'hFF, 4);

    // Multiple anodes, then an illegal glyph; neither may mark digits 0/1 as seen.
    push_err(2'b10);
    drive(8'hFC, gl(4'h8, 1'b0), 6);
    push_err(2'b01);
    drive(8'hFE, 8'hFC, 6);
    push_frame(32'hAAAAAABB, 8'h00, 8'h00, 8);
    for (int i = 2; i < 8; i++) drive(an_of(i), gl(4'hA, 1'b0), 6);
    drive(an_of(0), gl(4'hB, 1'b0), 6);
    drive(an_of(1), gl(4'hB, 1'b0), 6);
    drive(8'hFF, 8'hFF, 4);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) drive(an_of(i), gl(4'hC, 1'b0), 6);
    rst = 1'b1;
    AN  = 8'hFF;
    HEX = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(8'hFF, 8'hFF, 2);
    check("frame_valid cleared by reset", 64'(frame_valid), 64'd0);
    check("digits cleared by reset", 64'(digits), 64'd0);
    push_frame(32'hDDDDDDDD, 8'h00, 8'h00, 8);
    for (int i = 0; i < 8; i++) drive(an_of(i), gl(4'hD, 1'b0), 6);
    drive(8'hFF, 8'hFF, 4);

    // Three back-to-back frames.
    push_frame(32'hEEEEEEEE, 8'hFF, 8'h00, 8);
    push_frame(32'h01234567, 8'h00, 8'h00, 16);
    push_frame(32'h98989898, 8'h81, 8'h00, 24);
    for (int i = 0; i < 8; i++) drive(an_of(i), gl(4'hE, 1'b1), 6);
    for (int i = 0; i < 8; i++) drive(an_of(i), gl(4'(7 - i), 1'b0), 6);
    for (int i = 0; i < 8; i++) drive(an_of(i), gl((i % 2 == 1) ? 4'h9 : 4'h8, (i == 0) || (i == 7)), 6);
    drive(8'hFF, 8'hFF, 10);

    check("all expected frames seen", 64'(fq.size()), 64'd0);
    check("all expected errors seen", 64'(eq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning consecutive identical input cycles before a digit is captured (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port HEX  input  8  segment bus, active-low; bit0=a … bit6=g, bit7=dp; synchronous to clk.
REQ-005 SHALL have port AN  input  8  digit anodes, active-low, one-hot-low when a digit is driven; synchronous to clk.
REQ-006 SHALL have port digits  output  32  decoded nibbles; digit i at [4i+3:4i].
REQ-007 SHALL have port dp  output  8  decimal point per digit, 1 = lit.
REQ-008 SHALL have port blank  output  8  1 = digit had all segments a..g off.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when digits/dp/blank are updated.
REQ-010 SHALL have port frame_valid  output  1  high once at least one frame has been published.
REQ-011 SHALL have port err_glyph  output  1  one-cycle pulse: captured pattern not a legal glyph.
REQ-012 SHALL have port err_multi  output  1  one-cycle pulse: more than one AN bit low when a capture would occur.

Function
REQ-013 SHALL register {AN,HEX} each cycle; cnt resets to 0 when the new sample differs from the previous, otherwise increments, saturating at SETTLE_CYCLES.
REQ-014 SHALL use states IDLE, SETTLE, HOLD: IDLE while AN==8'hFF; AN!=8'hFF -> SETTLE; SETTLE -> HOLD when cnt reaches SETTLE_CYCLES (capture cycle); any input change in SETTLE or HOLD -> SETTLE (or IDLE if AN==8'hFF).
REQ-015 SHALL capture exactly once per HOLD entry; a pattern held longer is not re-captured.
REQ-016 SHALL decode a..g (after inversion) to nibbles 0-9,A,b,C,d,E,F; glyph 6 includes segment a, 7 is a,b,c only, 9 includes segment d.
REQ-017 SHALL treat a..g all off as legal: nibble 0, blank bit 1.
REQ-018 SHALL, on a legal capture with exactly one AN bit low at index i, write shadow nibble/dp/blank for i and set seen[i].
REQ-019 SHALL, on capture of an illegal glyph, pulse err_glyph, leave shadow and seen unchanged.
REQ-020 SHALL, at capture with >1 AN bit low, pulse err_multi, leave shadow and seen unchanged, and enter HOLD.
REQ-021 SHALL allow recapture of an already-seen digit before the frame completes; latest value wins.
REQ-022 SHALL, in the cycle after seen becomes 8'hFF, copy shadow to digits/dp/blank, pulse frame_done, set frame_valid, clear seen.
REQ-023 SHALL give capture-to-output latency: err pulses 1 cycle after capture cycle; frame_done 1 cycle after the completing capture.
REQ-024 SHALL, if a completing capture and a new capture coincide, complete the frame first; the new capture sets seen in the cleared mask.
REQ-025 SHALL keep outputs stable between frame_done pulses regardless of input activity.

Reset
REQ-026 SHALL, while rst is high, force state IDLE, cnt 0, seen 0, shadow 0, digits 0, dp 0, blank 0, frame_done 0, frame_valid 0, err_glyph 0, err_multi 0.
REQ-027 SHALL discard a partially collected frame on reset asserted mid-frame; no frame_done until 8 new digit captures after release.

Verification
REQ-028 SHALL cover: scan AN 8'hFE..8'h7F, 6 cycles each, glyphs for 0..7, dp on digit 3 only -> one frame_done, digits=32'h76543210, dp=8'h08, blank=0, frame_valid=1.
REQ-029 SHALL cover: SETTLE_CYCLES=4, each digit held 3 cycles -> no capture, no frame_done ever.
REQ-030 SHALL cover: digit 2 driven with HEX=8'hFF (blank), others with glyph F -> digits=32'hFFFFF0FF, blank=8'h04.
REQ-031 SHALL cover: AN=8'hFC held 6 cycles -> one err_multi pulse, seen unchanged; HEX a..g=7'b0000011 (illegal) -> one err_glyph pulse.
REQ-032 SHALL cover: rst pulsed after 5 digits captured, then full 8-digit scan -> exactly one frame_done, occurring after the 8th post-reset capture.
REQ-033 SHALL cover: continuous scan of 3 frames with changed values -> 3 frame_done pulses, outputs update only on those pulses.
